// File: rtl/alu_sequencer.sv
// Issue/writeback stage for the 8-bit ALU: small register file, two-cycle IDLE->EXEC
// sequencing, locally computed Z/N/C flags and a register load port.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic              instr_usec,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_carry_in,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SHR = 3'd1, OP_SHL = 3'd2, OP_CMP = 3'd7;

  typedef enum logic {IDLE, EXEC} state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
  } issue_t;

  state_t state, state_nxt;
  issue_t iss;
  logic [NREG-1:0][DATA_W-1:0] rf;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              z_nxt, n_nxt, c_nxt;
  logic              accept;

  assign accept   = (state == IDLE) && instr_valid && !ld_valid;
  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = (state == IDLE) && !ld_valid;
    alu_a        = '0;
    alu_b        = '0;
    alu_carry_in = 1'b0;
    alu_opcode   = '0;
    if (state == EXEC) begin
      alu_a        = iss.a;
      alu_b        = iss.b;
      alu_carry_in = iss.cin;
      alu_opcode   = iss.op;
    end
  end

  // Carry and compare results are derived here so the flags never depend on ALU internals.
  assign sum  = {1'b0, iss.a} + {1'b0, iss.b} + {{DATA_W{1'b0}}, iss.cin};
  assign diff = iss.a - iss.b;

  always_comb begin
    z_nxt = (alu_out == '0);
    n_nxt = alu_out[DATA_W-1];
    c_nxt = flag_c;
    case (iss.op)
      OP_ADD: c_nxt = sum[DATA_W];
      OP_SHR: c_nxt = iss.b[0];
      OP_SHL: c_nxt = iss.b[DATA_W-1];
      OP_CMP: begin
        z_nxt = (iss.a == iss.b);
        n_nxt = diff[DATA_W-1];
        c_nxt = (iss.a >= iss.b);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf       <= '0;
      iss      <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (state == IDLE) begin
        if (ld_valid)
          rf[ld_addr] <= ld_data;
        else if (instr_valid)
          iss <= '{op: instr_op, rd: instr_rd, a: rf[instr_rd], b: rf[instr_rs],
                   cin: instr_usec & flag_c};
      end else begin
        flag_z <= z_nxt;
        flag_n <= n_nxt;
        flag_c <= c_nxt;
        if (iss.op != OP_CMP) begin
          rf[iss.rd] <= alu_out;
          wb_valid   <= 1'b1;
          wb_addr    <= iss.rd;
          wb_data    <= alu_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU closes the loop, writebacks are
// checked against a scoreboard of hand-computed results.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, instr_valid, instr_ready, instr_usec, ld_valid;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_rs, ld_addr, wb_addr, dbg_addr;
  logic [7:0] ld_data, alu_a, alu_b, alu_out, wb_data, dbg_data;
  logic       alu_carry_in, wb_valid, flag_z, flag_n, flag_c;
  logic [2:0] alu_opcode;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
    logic       z, n, c;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  alu_sequencer #(.DATA_W(8), .NREG(4), .REG_AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_usec(instr_usec),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_opcode(alu_opcode),
    .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU; shifts insert carry_in at the vacated end.
  always_comb begin
    case (alu_opcode)
      3'd0:    alu_out = alu_a + alu_b + {7'd0, alu_carry_in};
      3'd1:    alu_out = {alu_carry_in, alu_b[7:1]};
      3'd2:    alu_out = {alu_b[6:0], alu_carry_in};
      3'd3:    alu_out = ~alu_a;
      3'd4:    alu_out = alu_a & alu_b;
      3'd5:    alu_out = alu_a | alu_b;
      3'd6:    alu_out = alu_a ^ alu_b;
      default: alu_out = 8'h5A;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      wb_t act, exp;
      act = '{addr: wb_addr, data: wb_data, z: flag_z, n: flag_n, c: flag_c};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got addr=%0d data=%h", wb_addr, wb_data);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL wb_scoreboard got a=%0d d=%h znc=%b%b%b want a=%0d d=%h znc=%b%b%b",
                   act.addr, act.data, act.z, act.n, act.c, exp.addr, exp.data, exp.z, exp.n, exp.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic reg_chk(input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("rf%0d", a), {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic flags_chk(input string name, input logic [2:0] exp);
    chk(name, {29'd0, flag_z, flag_n, flag_c}, {29'd0, exp});
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic expect_wb(input logic [1:0] a, input logic [7:0] d, input logic [2:0] znc);
    exp_q.push_back('{addr: a, data: d, z: znc[2], n: znc[1], c: znc[0]});
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic usec, input logic exp_wb);
    int n = 0;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_usec = usec; instr_valid = 1'b1;
    #1;
    while (!instr_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("wb_early", {31'd0, wb_valid}, 32'd0);
    chk("ready_exec", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    chk("wb_pulse", {31'd0, wb_valid}, {31'd0, exp_wb});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; ld_valid = 1'b0; instr_op = '0; instr_rd = '0;
    instr_rs = '0; instr_usec = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    flags_chk("rst_flags", 3'b000);
    reg_chk(2'd0, 8'h00);

    // 1: 7F + 01 -> 80, N set
    load(2'd0, 8'h7F); load(2'd1, 8'h01);
    expect_wb(2'd0, 8'h80, 3'b010);
    issue(3'd0, 2'd0, 2'd1, 1'b0, 1'b1);
    reg_chk(2'd0, 8'h80);

    // 2: FF + 01 wraps, then carry-in used
    load(2'd0, 8'hFF);
    expect_wb(2'd0, 8'h00, 3'b101);
    issue(3'd0, 2'd0, 2'd1, 1'b0, 1'b1);
    expect_wb(2'd0, 8'h02, 3'b000);
    issue(3'd0, 2'd0, 2'd1, 1'b1, 1'b1);
    reg_chk(2'd0, 8'h02);

    // 3: regain C=1, then shifts through carry with rd==rs
    load(2'd3, 8'hFF);
    expect_wb(2'd3, 8'h00, 3'b101);
    issue(3'd0, 2'd3, 2'd1, 1'b0, 1'b1);
    load(2'd2, 8'h03);
    flags_chk("load_keeps_flags", 3'b101);
    expect_wb(2'd2, 8'h81, 3'b011);
    issue(3'd1, 2'd2, 2'd2, 1'b1, 1'b1);
    expect_wb(2'd2, 8'h03, 3'b001);
    issue(3'd2, 2'd2, 2'd2, 1'b1, 1'b1);
    expect_wb(2'd2, 8'h00, 3'b101);
    issue(3'd6, 2'd2, 2'd2, 1'b0, 1'b1);
    expect_wb(2'd2, 8'hFF, 3'b011);
    issue(3'd3, 2'd2, 2'd0, 1'b0, 1'b1);
    load(2'd0, 8'hF0); load(2'd1, 8'h3C);
    expect_wb(2'd0, 8'h30, 3'b001);
    issue(3'd4, 2'd0, 2'd1, 1'b0, 1'b1);
    expect_wb(2'd1, 8'h3C, 3'b001);
    issue(3'd5, 2'd1, 2'd0, 1'b0, 1'b1);

    // 4: compares leave registers alone
    load(2'd0, 8'h05); load(2'd1, 8'h05);
    issue(3'd7, 2'd0, 2'd1, 1'b0, 1'b0);
    flags_chk("cmp_eq_flags", 3'b101);
    reg_chk(2'd0, 8'h05);
    load(2'd1, 8'h06);
    issue(3'd7, 2'd0, 2'd1, 1'b0, 1'b0);
    flags_chk("cmp_lt_flags", 3'b010);
    reg_chk(2'd0, 8'h05);

    // 5: load wins over a simultaneous instruction
    instr_op = 3'd0; instr_rd = 2'd3; instr_rs = 2'd3; instr_usec = 1'b0; instr_valid = 1'b1;
    ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 8'h0A;
    #1;
    chk("ready_during_load", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    expect_wb(2'd3, 8'h14, 3'b000);
    issue(3'd0, 2'd3, 2'd3, 1'b0, 1'b1);
    reg_chk(2'd3, 8'h14);

    // 6: reset in EXEC aborts the write
    load(2'd1, 8'hFF); load(2'd0, 8'h01);
    expect_wb(2'd0, 8'h00, 3'b101);
    issue(3'd0, 2'd0, 2'd1, 1'b0, 1'b1);
    load(2'd0, 8'h55);
    instr_op = 3'd0; instr_rd = 2'd0; instr_rs = 2'd1; instr_usec = 1'b1; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("exec_before_reset", {29'd0, alu_opcode}, 32'd0);
    chk("exec_alu_a", {24'd0, alu_a}, 32'h55);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_wb", {31'd0, wb_valid}, 32'd0);
    flags_chk("abort_flags", 3'b000);
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 4; i++) reg_chk(i[1:0], 8'h00);
    @(posedge clk); #1;
    chk("abort_no_late_wb", {31'd0, wb_valid}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
